// File: rtl/rc6_img_ctrl.sv
// rc6_img_ctrl: frame sequencer for rc6_core (key setup, block streaming, watchdog).
// Build option: define RC6_CTRL_CBC_EN for CBC chaining; the default build is ECB.
module rc6_img_ctrl #(
    parameter int BLK_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [127:0]       i_key,
    input  logic [127:0]       i_iv,
    input  logic [BLK_W-1:0]   i_nblk,
    input  logic [127:0]       s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [127:0]       m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               o_core_flag,
    output logic [127:0]       o_core_key,
    output logic               o_core_key_en,
    input  logic               i_core_key_ok,
    output logic [127:0]       o_core_din,
    output logic               o_core_din_en,
    input  logic [127:0]       i_core_dout,
    input  logic               i_core_dout_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    // state    | meaning
    // IDLE     | wait for start      KEY_REQ  | key_en pulse     KEY_WAIT | wait key_ok rise
    // FEED     | accept input block  WAIT     | wait core result OUT      | present result
    // DONE     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_KEY_REQ, S_KEY_WAIT, S_FEED, S_WAIT, S_OUT, S_DONE
    } state_t;

    localparam int WD_W = 16;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [127:0]       key_q, key_d;
    logic [BLK_W-1:0]   nblk_q, nblk_d;
    logic [BLK_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               key_ok_q;
    logic [127:0]       din_q, din_d;
    logic               din_en_q, din_en_d;
    logic [127:0]       mdata_q, mdata_d;
    logic               err_q, err_d;
    logic               key_ok_rise;
    logic [127:0]       din_mix, res_mix;

`ifdef RC6_CTRL_CBC_EN
    logic [127:0] chain_q, chain_d;

    assign din_mix = mode_q ? (s_data ^ chain_q) : s_data;
    assign res_mix = mode_q ? i_core_dout : (i_core_dout ^ chain_q);

    // Decrypt chains on the ciphertext, which is still held in din_q.
    always_comb begin
        chain_d = chain_q;
        if (state_q == S_IDLE && i_start) begin
            chain_d = i_iv;
        end else if (state_q == S_WAIT && i_core_dout_en) begin
            chain_d = mode_q ? i_core_dout : din_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end
`else
    logic unused_iv;
    assign unused_iv = ^i_iv;
    assign din_mix   = s_data;
    assign res_mix   = i_core_dout;
`endif

    assign key_ok_rise = i_core_key_ok & ~key_ok_q;
    assign cnt_inc     = cnt_q + BLK_W'(1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        key_d    = key_q;
        nblk_d   = nblk_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        din_d    = din_q;
        din_en_d = 1'b0;
        mdata_d  = mdata_q;
        err_d    = err_q;

        s_ready       = (state_q == S_FEED);
        m_valid       = (state_q == S_OUT);
        o_core_key_en = (state_q == S_KEY_REQ);
        o_busy        = (state_q != S_IDLE);
        o_done        = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    key_d   = i_key;
                    nblk_d  = i_nblk;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_KEY_REQ;
                end
            end
            S_KEY_REQ: begin
                wd_d    = WD_LOAD;
                state_d = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (key_ok_rise) begin
                    state_d = (nblk_q == '0) ? S_DONE : S_FEED;
                end else if (wd_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            S_FEED: begin
                if (s_valid) begin
                    din_d    = din_mix;
                    din_en_d = 1'b1;
                    wd_d     = WD_LOAD;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_core_dout_en) begin
                    mdata_d = res_mix;
                    state_d = S_OUT;
                end else if (wd_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == nblk_q) ? S_DONE : S_FEED;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            key_q    <= '0;
            nblk_q   <= '0;
            cnt_q    <= '0;
            wd_q     <= '0;
            key_ok_q <= 1'b0;
            din_q    <= '0;
            din_en_q <= 1'b0;
            mdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            key_q    <= key_d;
            nblk_q   <= nblk_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            key_ok_q <= i_core_key_ok;
            din_q    <= din_d;
            din_en_q <= din_en_d;
            mdata_q  <= mdata_d;
            err_q    <= err_d;
        end
    end

    assign m_data        = mdata_q;
    assign o_core_flag   = mode_q;
    assign o_core_key    = key_q;
    assign o_core_din    = din_q;
    assign o_core_din_en = din_en_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_rc6_img_ctrl.sv
// Bench for rc6_img_ctrl: RC6-32/20/16 core model, frame table with scoreboard, corner sequences.
module tb_rc6_img_ctrl;
    localparam int BLK_W    = 16;
    localparam int TIMEOUT  = 255;
    localparam int KEY_LAT  = 4;
    localparam int CORE_LAT = 5;
    localparam logic [127:0] IV = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'hdeadbeef0badf00dcafef00d12345678;

    logic               i_clk, i_rst, i_start, i_mode;
    logic [127:0]       i_key, i_iv;
    logic [BLK_W-1:0]   i_nblk;
    logic [127:0]       s_data;
    logic               s_valid, s_ready;
    logic [127:0]       m_data;
    logic               m_valid, m_ready;
    logic               o_core_flag, o_core_key_en, i_core_key_ok;
    logic [127:0]       o_core_key, o_core_din, i_core_dout;
    logic               o_core_din_en, i_core_dout_en;
    logic               o_busy, o_done, o_err;

    rc6_img_ctrl #(.BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_key(i_key), .i_iv(i_iv), .i_nblk(i_nblk),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .o_core_flag(o_core_flag), .o_core_key(o_core_key), .o_core_key_en(o_core_key_en),
        .i_core_key_ok(i_core_key_ok), .o_core_din(o_core_din), .o_core_din_en(o_core_din_en),
        .i_core_dout(i_core_dout), .i_core_dout_en(i_core_dout_en),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int v, input int lo, input int hi);
        n_tests++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    // RC6-32/20/16; word A is blk[31:0], key word L[j] is key[32j+31:32j].
    function automatic logic [127:0] rc6(input logic [127:0] key, input logic [127:0] blk, input logic enc);
        logic [31:0] S [44];
        logic [31:0] L [4];
        logic [31:0] a, b, c, d, t, u, x;
        int i, j;
        for (int k = 0; k < 4; k++) L[k] = key[32*k +: 32];
        S[0] = 32'hB7E15163;
        for (int k = 1; k < 44; k++) S[k] = S[k-1] + 32'h9E3779B9;
        a = '0; b = '0; i = 0; j = 0;
        for (int k = 0; k < 132; k++) begin
            S[i] = rotl(S[i] + a + b, 5'd3);
            a = S[i];
            x = a + b;
            L[j] = rotl(L[j] + x, x[4:0]);
            b = L[j];
            i = (i + 1) % 44;
            j = (j + 1) % 4;
        end
        a = blk[31:0]; b = blk[63:32]; c = blk[95:64]; d = blk[127:96];
        if (enc) begin
            b = b + S[0];
            d = d + S[1];
            for (int r = 1; r <= 20; r++) begin
                x = b * ((b << 1) + 32'd1); t = rotl(x, 5'd5);
                x = d * ((d << 1) + 32'd1); u = rotl(x, 5'd5);
                a = rotl(a ^ t, u[4:0]) + S[2*r];
                c = rotl(c ^ u, t[4:0]) + S[2*r+1];
                x = a; a = b; b = c; c = d; d = x;
            end
            a = a + S[42];
            c = c + S[43];
        end else begin
            c = c - S[43];
            a = a - S[42];
            for (int r = 20; r >= 1; r--) begin
                x = d; d = c; c = b; b = a; a = x;
                x = d * ((d << 1) + 32'd1); u = rotl(x, 5'd5);
                x = b * ((b << 1) + 32'd1); t = rotl(x, 5'd5);
                c = rotr(c - S[2*r+1], t[4:0]) ^ u;
                a = rotr(a - S[2*r], u[4:0]) ^ t;
            end
            d = d - S[1];
            b = b - S[0];
        end
        return {d, c, b, a};
    endfunction

    // Core model: key_ok drops on key_en and rises KEY_LAT cycles later; result after CORE_LAT.
    bit           core_hang = 1'b0;
    bit           keep_ok   = 1'b0;
    int           key_cnt, dly;
    logic [127:0] pend;

    initial begin
        i_core_key_ok  = 1'b0;
        i_core_dout_en = 1'b0;
        i_core_dout    = '0;
        pend           = '0;
        key_cnt        = 0;
        dly            = 0;
        forever begin
            @(negedge i_clk);
            i_core_dout_en = 1'b0;
            if (i_rst) begin
                i_core_key_ok = 1'b0;
                key_cnt       = 0;
                dly           = 0;
            end else begin
                if (o_core_key_en) begin
                    if (!keep_ok) i_core_key_ok = 1'b0;
                    key_cnt = KEY_LAT;
                end else if (key_cnt > 0) begin
                    key_cnt--;
                    if (key_cnt == 0) i_core_key_ok = 1'b1;
                end
                if (o_core_din_en) begin
                    pend = rc6(o_core_key, o_core_din, o_core_flag);
                    dly  = CORE_LAT;
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0 && !core_hang) begin
                        i_core_dout    = pend;
                        i_core_dout_en = 1'b1;
                    end
                end
            end
        end
    end

    logic [127:0] blk_in  [8];
    logic [127:0] blk_out [8];
    logic [127:0] plain   [8];
    logic [127:0] exp_q   [$];
    logic [127:0] chain_m;

    task automatic run_frame(input logic mode, input logic [127:0] key, input int nblk,
                             input bit gaps, input int stall);
        exp_q.delete();
        chain_m = IV;
        i_mode  = mode;
        i_key   = key;
        i_iv    = IV;
        i_nblk  = BLK_W'(nblk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        chk("key_en_after_start", o_core_key_en, 1);
        chk("err_clear_on_start", o_err, 0);
        fork
            begin : drv
                int g;
                logic [127:0] din_e, res;
                for (int b = 0; b < nblk; b++) begin
                    if (gaps) repeat ($urandom_range(0, 3)) @(negedge i_clk);
                    s_data  = blk_in[b];
                    s_valid = 1'b1;
                    g = 0;
                    while (!s_ready && g < 2000) begin
                        @(negedge i_clk);
                        g++;
                    end
                    chk("s_ready_wait", s_ready, 1);
`ifdef RC6_CTRL_CBC_EN
                    if (mode) begin
                        din_e   = blk_in[b] ^ chain_m;
                        res     = rc6(key, din_e, 1'b1);
                        chain_m = res;
                    end else begin
                        din_e   = blk_in[b];
                        res     = rc6(key, din_e, 1'b0) ^ chain_m;
                        chain_m = blk_in[b];
                    end
`else
                    din_e = blk_in[b];
                    res   = rc6(key, din_e, mode);
`endif
                    exp_q.push_back(res);
                    @(negedge i_clk);
                    s_valid = 1'b0;
                    chk("din_en_after_hs", o_core_din_en, 1);
                    chk("s_ready_low_after_hs", s_ready, 0);
                    chk("core_din", o_core_din, din_e);
                    chk("core_flag", o_core_flag, mode);
                end
            end
            begin : mon
                int g;
                logic [127:0] held, e;
                for (int b = 0; b < nblk; b++) begin
                    m_ready = (b == stall) ? 1'b0 : 1'b1;
                    g = 0;
                    while (!m_valid && g < 2000) begin
                        @(negedge i_clk);
                        g++;
                    end
                    chk("m_valid_wait", m_valid, 1);
                    if (b == stall) begin
                        held = m_data;
                        repeat (10) begin
                            @(negedge i_clk);
                            chk("stall_m_valid", m_valid, 1);
                            chk("stall_m_data", m_data, held);
                            chk("stall_s_ready", s_ready, 0);
                        end
                        m_ready = 1'b1;
                    end
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    blk_out[b] = m_data;
                    chk("m_data", m_data, e);
                    @(negedge i_clk);
                    if (b == nblk - 1) begin
                        chk("done_after_last_hs", o_done, 1);
                        @(negedge i_clk);
                        chk("idle_after_done", o_busy, 0);
                        chk("done_single", o_done, 0);
                    end else begin
                        chk("s_ready_next_block", s_ready, 1);
                    end
                end
            end
        join
        chk("scoreboard_empty", 128'(exp_q.size()), 0);
    endtask

    typedef struct {
        logic         mode;
        logic [127:0] key;
        int           nblk;
        bit           gaps;
        int           stall;
        bit           from_prev;
    } frame_t;

    frame_t tbl [4];

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int g, n;
        bit seen;
        int keyen_cnt;

        tbl[0] = '{1'b1, 128'h0, 3, 1'b0, -1, 1'b0};
        tbl[1] = '{1'b0, 128'h0, 3, 1'b0, -1, 1'b1};
        tbl[2] = '{1'b1, K1,     4, 1'b1,  1, 1'b0};
        tbl[3] = '{1'b0, K1,     4, 1'b1, -1, 1'b1};

        i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_key = '0; i_iv = '0; i_nblk = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rst_ctrl_outs", {s_ready, m_valid, o_core_flag, o_core_key_en, o_core_din_en,
                              o_busy, o_done, o_err}, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_core_key", o_core_key, 0);
        chk("rst_core_din", o_core_din, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < tbl[f].nblk; b++) begin
                if (tbl[f].from_prev) begin
                    blk_in[b] = blk_out[b];
                end else begin
                    blk_in[b] = (f == 0) ? 128'(b) : {$urandom, $urandom, $urandom, $urandom};
                    plain[b]  = blk_in[b];
                end
            end
            run_frame(tbl[f].mode, tbl[f].key, tbl[f].nblk, tbl[f].gaps, tbl[f].stall);
            if (tbl[f].from_prev) begin
                for (int b = 0; b < tbl[f].nblk; b++) chk("roundtrip_plain", blk_out[b], plain[b]);
            end
        end

        // nblk=0 with start pulses while busy
        i_mode = 1'b1; i_key = K2; i_nblk = '0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("z_key_en", o_core_key_en, 1);
        i_mode = 1'b0; i_key = ~K2; i_nblk = BLK_W'(5);
        g = 0; seen = 1'b0; keyen_cnt = 0;
        while (!o_done && g < 100) begin
            i_start = (g == 1 || g == 3) ? 1'b1 : 1'b0;
            @(negedge i_clk);
            g++;
            if (s_ready) seen = 1'b1;
            if (o_core_key_en) keyen_cnt++;
        end
        i_start = 1'b0;
        chk("z_done", o_done, 1);
        chk("z_err", o_err, 0);
        chk("z_s_ready_never", seen, 0);
        chk("z_single_key_en", keyen_cnt, 0);
        chk("z_flag_kept", o_core_flag, 1);
        chk("z_key_kept", o_core_key, K2);
        repeat (3) begin
            @(negedge i_clk);
            chk("z_stays_idle", o_busy, 0);
        end

        // core never returns a result: watchdog in WAIT
        core_hang = 1'b1;
        i_mode = 1'b1; i_key = K1; i_nblk = BLK_W'(1); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        g = 0;
        while (!s_ready && g < 100) begin
            @(negedge i_clk);
            g++;
        end
        chk("to_feed", s_ready, 1);
        s_data = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0; s_valid = 1'b1;
        @(negedge i_clk);
        s_valid = 1'b0;
        chk("to_din_en", o_core_din_en, 1);
        n = 0; seen = 1'b0;
        while (!o_done && n < TIMEOUT + 50) begin
            @(negedge i_clk);
            n++;
            if (m_valid) seen = 1'b1;
        end
        chk_range("to_cycles", n, TIMEOUT, TIMEOUT + 1);
        chk("to_done", o_done, 1);
        chk("to_err", o_err, 1);
        chk("to_no_m_valid", seen, 0);
        @(negedge i_clk);
        chk("to_idle", o_busy, 0);
        chk("to_err_sticky", o_err, 1);
        core_hang = 1'b0;
        blk_in[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        run_frame(1'b1, K1, 1, 1'b0, -1);

        // key_ok already high: no rising edge, watchdog in KEY_WAIT
        keep_ok = 1'b1;
        i_mode = 1'b0; i_key = K2; i_nblk = BLK_W'(2); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        n = 0; seen = 1'b0;
        while (!o_done && n < TIMEOUT + 50) begin
            @(negedge i_clk);
            n++;
            if (s_ready) seen = 1'b1;
        end
        chk_range("kw_cycles", n, TIMEOUT, TIMEOUT + 2);
        chk("kw_err", o_err, 1);
        chk("kw_no_feed", seen, 0);
        keep_ok = 1'b0;
        @(negedge i_clk);
        chk("kw_idle", o_busy, 0);

        // reset while in WAIT, then a clean frame
        i_mode = 1'b1; i_key = K1; i_nblk = BLK_W'(2); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        g = 0;
        while (!s_ready && g < 100) begin
            @(negedge i_clk);
            g++;
        end
        s_data = 128'hfeed; s_valid = 1'b1;
        @(negedge i_clk);
        s_valid = 1'b0;
        chk("rw_in_wait", o_core_din_en, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rw_ctrl_outs", {s_ready, m_valid, o_core_flag, o_core_key_en, o_core_din_en,
                             o_busy, o_done, o_err}, 0);
        chk("rw_core_key", o_core_key, 0);
        chk("rw_core_din", o_core_din, 0);
        chk("rw_m_data", m_data, 0);
        repeat (4) begin
            @(negedge i_clk);
            chk("rw_no_done", {o_done, o_busy}, 0);
        end
        blk_in[0] = 128'h0a0b0c0d;
        blk_in[1] = 128'hffffffff_00000000_ffffffff_00000000;
        run_frame(1'b1, K2, 2, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
